// File: rtl/digit_glyph_overlay.sv
// Paints a 3x3 block glyph of one plate digit into a live RGB stream, with an optional box outline.
// All outputs trail the inputs by two pixel clocks; digit and box change only on an i_vs rise.
module digit_glyph_overlay #(
    parameter int unsigned CELL_W        = 18,
    parameter int unsigned CELL_H        = 25,
    parameter logic [23:0] FG_COLOR      = 24'hFF0000,
    parameter bit          OUTLINE_EN    = 1'b1,
    parameter logic [23:0] OUTLINE_COLOR = 24'h00FF00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic        i_de,
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    input  logic [23:0] i_data,
    input  logic [3:0]  digit,
    input  logic        digit_valid,
    input  logic [11:0] box_left,
    input  logic [11:0] box_up,
    output logic [23:0] o_data,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_de,
    output logic        o_th,
    output logic [8:0]  glyph_code
);
    localparam logic [12:0] CellH  = 13'(CELL_H);
    localparam logic [12:0] BoxW   = 13'(3 * CELL_W);
    localparam logic [12:0] BoxH   = 13'(3 * CELL_H);
    localparam logic [11:0] SubMax = 12'(CELL_W - 1);

    logic [3:0]  r_pend_digit, r_act_digit;
    logic [11:0] r_pend_left, r_pend_up, r_act_left, r_act_up;
    logic        r_pend_vld, r_act_vld, r_vs_d;
    logic [8:0]  r_glyph;
    logic [1:0]  r_col;
    logic [11:0] r_sub;

    logic        r1_hs, r1_vs, r1_de, r1_in_box, r1_edge;
    logic [11:0] r1_x, r1_y;
    logic [23:0] r1_data;
    logic [3:0]  r1_cell;

    logic        w_frame_start, w_x_in, w_in_box, w_edge, w_bit;
    logic [1:0]  w_col, w_col_nxt, w_row;
    logic [11:0] w_sub, w_sub_nxt;
    logic [12:0] w_x13, w_y13, w_left13, w_up13;
    logic [3:0]  w_cell;
    logic [8:0]  w_glyph;
    logic [15:0] w_glyph_ext;

    assign w_frame_start = i_vs & ~r_vs_d;
    assign w_x13    = {1'b0, i_x};
    assign w_y13    = {1'b0, i_y};
    assign w_left13 = {1'b0, r_act_left};
    assign w_up13   = {1'b0, r_act_up};

    always_comb begin
        w_glyph = 9'h000;
        case (r_act_digit)
            4'd0:    w_glyph = 9'h1EF;
            4'd1:    w_glyph = 9'h092;
            4'd2:    w_glyph = 9'h1D7;
            4'd3:    w_glyph = 9'h1F7;
            4'd4:    w_glyph = 9'h1FE;
            4'd5:    w_glyph = 9'h19F;
            4'd6:    w_glyph = 9'h1DB;
            4'd7:    w_glyph = 9'h127;
            4'd8:    w_glyph = 9'h1FF;
            4'd9:    w_glyph = 9'h13F;
            default: w_glyph = 9'h000;
        endcase
    end

    // Column of the current pixel: counter restarts on the box's left edge, 3 means outside.
    always_comb begin
        w_col     = 2'd3;
        w_sub     = '0;
        w_col_nxt = 2'd3;
        w_sub_nxt = '0;
        if (i_de) begin
            if (i_x == r_act_left) begin
                w_col = 2'd0;
                w_sub = '0;
            end else begin
                w_col = r_col;
                w_sub = r_sub;
            end
        end
        if (i_de && w_col != 2'd3) begin
            if (w_sub == SubMax) begin
                w_col_nxt = w_col + 2'd1;
            end else begin
                w_col_nxt = w_col;
                w_sub_nxt = w_sub + 12'd1;
            end
        end
    end

    always_comb begin
        w_row = 2'd3;
        if (w_y13 >= w_up13 && w_y13 < w_up13 + CellH)                      w_row = 2'd0;
        else if (w_y13 >= w_up13 + CellH && w_y13 < w_up13 + 13'd2 * CellH) w_row = 2'd1;
        else if (w_y13 >= w_up13 + 13'd2 * CellH && w_y13 < w_up13 + BoxH)  w_row = 2'd2;
    end

    // The x-range test clips the counter when a line wraps past 4095 back to 0.
    assign w_x_in   = (w_x13 >= w_left13) && (w_x13 < w_left13 + BoxW);
    assign w_in_box = r_act_vld && i_de && w_x_in && (w_col != 2'd3) && (w_row != 2'd3);
    assign w_cell   = {2'b00, w_row} * 4'd3 + {2'b00, w_col};
    assign w_edge   = (w_x13 == w_left13) || (w_x13 == w_left13 + BoxW - 13'd1) ||
                      (w_y13 == w_up13)   || (w_y13 == w_up13 + BoxH - 13'd1);

    assign w_glyph_ext = {7'b0, r_glyph};
    assign w_bit       = w_glyph_ext[r1_cell];
    assign glyph_code  = r_glyph;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_digit <= 4'hF;
            r_pend_left  <= '0;
            r_pend_up    <= '0;
            r_pend_vld   <= 1'b0;
            r_act_digit  <= 4'hF;
            r_act_left   <= '0;
            r_act_up     <= '0;
            r_act_vld    <= 1'b0;
            r_vs_d       <= 1'b0;
            r_glyph      <= '0;
            r_col        <= 2'd3;
            r_sub        <= '0;
        end else begin
            r_vs_d  <= i_vs;
            r_glyph <= w_glyph;
            r_col   <= w_col_nxt;
            r_sub   <= w_sub_nxt;
            if (digit_valid) begin
                r_pend_digit <= digit;
                r_pend_left  <= box_left;
                r_pend_up    <= box_up;
                r_pend_vld   <= 1'b1;
            end
            if (w_frame_start) begin
                if (digit_valid) begin
                    r_act_digit <= digit;
                    r_act_left  <= box_left;
                    r_act_up    <= box_up;
                    r_act_vld   <= 1'b1;
                end else begin
                    r_act_digit <= r_pend_digit;
                    r_act_left  <= r_pend_left;
                    r_act_up    <= r_pend_up;
                    r_act_vld   <= r_pend_vld;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_hs <= 1'b0; r1_vs <= 1'b0; r1_de <= 1'b0;
            r1_x <= '0; r1_y <= '0; r1_data <= '0;
            r1_in_box <= 1'b0; r1_cell <= '0; r1_edge <= 1'b0;
            o_hs <= 1'b0; o_vs <= 1'b0; o_de <= 1'b0;
            o_x <= '0; o_y <= '0; o_data <= '0; o_th <= 1'b0;
        end else begin
            r1_hs     <= i_hs;
            r1_vs     <= i_vs;
            r1_de     <= i_de;
            r1_x      <= i_x;
            r1_y      <= i_y;
            r1_data   <= i_data;
            r1_in_box <= w_in_box;
            r1_cell   <= w_cell;
            r1_edge   <= w_edge;
            o_hs      <= r1_hs;
            o_vs      <= r1_vs;
            o_de      <= r1_de;
            o_x       <= r1_x;
            o_y       <= r1_y;
            o_data    <= r1_data;
            o_th      <= 1'b0;
            if (r1_in_box && w_bit) begin
                o_data <= FG_COLOR;
                o_th   <= 1'b1;
            end else if (r1_in_box && r1_edge && OUTLINE_EN) begin
                o_data <= OUTLINE_COLOR;
            end
        end
    end
endmodule

// File: tb/tb_digit_glyph_overlay.sv
// Random-data video bench for digit_glyph_overlay against a per-pixel arithmetic reference model.
module tb_digit_glyph_overlay;
    localparam int CW = 18;
    localparam int CH = 25;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_hs = 0, i_vs = 0, i_de = 0, digit_valid = 0;
    logic [11:0] i_x = 0, i_y = 0, box_left = 0, box_up = 0;
    logic [23:0] i_data = 0;
    logic [3:0]  digit = 0;
    logic [23:0] o_data;
    logic [11:0] o_x, o_y;
    logic        o_hs, o_vs, o_de, o_th;
    logic [8:0]  glyph_code;

    digit_glyph_overlay dut (
        .clk(clk), .rst_n(rst_n), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_x(i_x), .i_y(i_y),
        .i_data(i_data), .digit(digit), .digit_valid(digit_valid), .box_left(box_left),
        .box_up(box_up), .o_data(o_data), .o_x(o_x), .o_y(o_y), .o_hs(o_hs), .o_vs(o_vs),
        .o_de(o_de), .o_th(o_th), .glyph_code(glyph_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] data;
        logic        th, hs, vs, de;
        logic [11:0] x, y;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int m_pend_d, m_pend_l, m_pend_u, m_act_d, m_act_l, m_act_u;
    bit m_pend_v, m_act_v, m_prev_vs;
    logic [8:0] glyph_tab [16] = '{9'h1EF, 9'h092, 9'h1D7, 9'h1F7, 9'h1FE, 9'h19F, 9'h1DB,
                                   9'h127, 9'h1FF, 9'h13F, 9'h000, 9'h000, 9'h000, 9'h000,
                                   9'h000, 9'h000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_pend_d = 15; m_pend_l = 0; m_pend_u = 0; m_pend_v = 0;
        m_act_d = 15;  m_act_l = 0;  m_act_u = 0;  m_act_v = 0;
        m_prev_vs = 0;
        q.delete();
    endtask

    function automatic exp_t model_pixel();
        exp_t e;
        int x, y, col, row;
        bit inb, edg;
        x = int'(i_x);
        y = int'(i_y);
        e.data = i_data; e.th = 1'b0; e.hs = i_hs; e.vs = i_vs; e.de = i_de;
        e.x = i_x; e.y = i_y;
        inb = m_act_v && i_de && x >= m_act_l && x < m_act_l + 3 * CW &&
              y >= m_act_u && y < m_act_u + 3 * CH;
        if (inb) begin
            col = (x - m_act_l) / CW;
            row = (y - m_act_u) / CH;
            edg = x == m_act_l || x == m_act_l + 3 * CW - 1 ||
                  y == m_act_u || y == m_act_u + 3 * CH - 1;
            if (glyph_tab[m_act_d][row * 3 + col]) begin
                e.data = 24'hFF0000;
                e.th   = 1'b1;
            end else if (edg) begin
                e.data = 24'h00FF00;
            end
        end
        return e;
    endfunction

    task automatic step();
        exp_t e;
        q.push_back(model_pixel());
        if (i_vs && !m_prev_vs) begin
            if (digit_valid) begin
                m_act_d = int'(digit); m_act_l = int'(box_left); m_act_u = int'(box_up);
                m_act_v = 1;
            end else begin
                m_act_d = m_pend_d; m_act_l = m_pend_l; m_act_u = m_pend_u; m_act_v = m_pend_v;
            end
        end
        if (digit_valid) begin
            m_pend_d = int'(digit); m_pend_l = int'(box_left); m_pend_u = int'(box_up);
            m_pend_v = 1;
        end
        m_prev_vs = i_vs;
        @(posedge clk);
        #1;
        if (q.size() == 2) begin
            e = q.pop_front();
            chk("o_data", 32'(o_data), 32'(e.data));
            chk("o_th", 32'(o_th), 32'(e.th));
            chk("o_x", 32'(o_x), 32'(e.x));
            chk("o_y", 32'(o_y), 32'(e.y));
            chk("o_hs", 32'(o_hs), 32'(e.hs));
            chk("o_vs", 32'(o_vs), 32'(e.vs));
            chk("o_de", 32'(o_de), 32'(e.de));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_data"}, 32'(o_data), 0);
        chk({tag, "_th"}, 32'(o_th), 0);
        chk({tag, "_x"}, 32'(o_x), 0);
        chk({tag, "_y"}, 32'(o_y), 0);
        chk({tag, "_hs"}, 32'(o_hs), 0);
        chk({tag, "_vs"}, 32'(o_vs), 0);
        chk({tag, "_de"}, 32'(o_de), 0);
        chk({tag, "_glyph"}, 32'(glyph_code), 0);
    endtask

    task automatic strobe(input int d, input int l, input int u);
        digit_valid = 1; digit = 4'(d); box_left = 12'(l); box_up = 12'(u);
        i_data = 24'($urandom);
        step();
        digit_valid = 0;
    endtask

    // bypass=1 strobes the given digit/box in the same cycle as the i_vs rise.
    task automatic new_frame(input bit bypass, input int d, input int l, input int u);
        i_de = 0; i_hs = 0; i_vs = 0;
        repeat (2) begin i_data = 24'($urandom); step(); end
        i_vs = 1;
        if (bypass) strobe(d, l, u);
        else begin i_data = 24'($urandom); step(); end
        repeat (3) begin i_data = 24'($urandom); step(); end
        chk("glyph_code", 32'(glyph_code), 32'(glyph_tab[m_act_d]));
    endtask

    task automatic line(input int y, input int xs, input int n);
        i_hs = 1; i_de = 0;
        repeat (2) begin i_data = 24'($urandom); step(); end
        i_hs = 0;
        i_y = 12'(y);
        for (int k = 0; k < n; k++) begin
            i_de = 1;
            i_x = 12'((xs + k + 8192) % 4096);
            i_data = 24'($urandom);
            step();
        end
        i_de = 0;
    endtask

    // Lines across every row boundary of the active box, each spanning the box plus margins.
    task automatic box_lines();
        int ys [11];
        int l, u;
        l = m_act_l; u = m_act_u;
        ys = '{u - 1, u, u + 10, u + CH - 1, u + CH, u + 37, u + 2 * CH - 1, u + 2 * CH,
               u + 60, u + 3 * CH - 1, u + 3 * CH};
        for (int i = 0; i < 11; i++) begin
            if (ys[i] >= 0 && ys[i] <= 4095) line(ys[i], l - 3, 3 * CW + 6);
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1;

        // No strobe since reset: pure pass-through, no outline even at box (0,0).
        new_frame(0, 0, 0, 0);
        for (int y = 0; y < 3; y++) line(y, 0, 60);
        line(77, 3000, 20);

        strobe(8, 100, 50);
        new_frame(0, 0, 0, 0);
        box_lines();

        strobe(0, 100, 50);
        new_frame(0, 0, 0, 0);
        box_lines();

        // Mid-frame strobe must not disturb the frame being drawn.
        strobe(8, 100, 50);
        new_frame(0, 0, 0, 0);
        line(60, 97, 60);
        strobe(1, 100, 50);
        line(300, 97, 60);
        box_lines();
        new_frame(0, 0, 0, 0);
        box_lines();
        new_frame(1, 7, 100, 50);
        box_lines();

        // Box hanging off the right and bottom edges; lines wrap x back to 0.
        strobe(8, 4080, 4050);
        new_frame(0, 0, 0, 0);
        box_lines();

        for (int f = 0; f < 6; f++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            if (mode == 0) begin
                strobe(int'($urandom_range(0, 15)), int'($urandom_range(0, 4095)),
                       int'($urandom_range(0, 4095)));
                if ($urandom_range(0, 1) == 1)
                    strobe(int'($urandom_range(0, 9)), int'($urandom_range(0, 4095)),
                           int'($urandom_range(0, 4095)));
                new_frame(0, 0, 0, 0);
            end else if (mode == 1) begin
                new_frame(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 4095)),
                          int'($urandom_range(0, 4095)));
            end else begin
                new_frame(0, 0, 0, 0);
            end
            box_lines();
            if ($urandom_range(0, 1) == 1)
                strobe(int'($urandom_range(0, 9)), int'($urandom_range(0, 4095)),
                       int'($urandom_range(0, 4095)));
            box_lines();
        end

        // Asynchronous reset in the middle of a painted line.
        strobe(8, 200, 100);
        new_frame(0, 0, 0, 0);
        i_hs = 0; i_y = 12'd110;
        for (int k = 0; k < 20; k++) begin
            i_de = 1; i_x = 12'(195 + k); i_data = 24'($urandom);
            step();
        end
        rst_n = 0;
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1;
        i_de = 0;
        model_reset();
        new_frame(0, 0, 0, 0);
        line(110, 195, 60);
        for (int y = 0; y < 2; y++) line(y, 0, 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
